vga_timing_gen: RTL
===================

VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 SHALL have parameter H_RES, default 640, visible pixels per line.
REQ-002 SHALL have parameter V_RES, default 480, visible lines per frame.
REQ-003 SHALL have parameters H_FP/H_SYNC/H_BP, defaults 16/96/48, horizontal front porch, sync pulse and back porch in pixels.
REQ-004 SHALL have parameters V_FP/V_SYNC/V_BP, defaults 10/2/33, vertical front porch, sync pulse and back porch in lines.
REQ-005 SHALL have parameter PX_DIV, default 2, system clocks per pixel (board 50 MHz / 25 MHz pixel); legal range 1..16.
REQ-006 SHALL derive H_TOTAL = H_RES+H_FP+H_SYNC+H_BP (800) and V_TOTAL = V_RES+V_FP+V_SYNC+V_BP (525); HS_W = clog2(H_TOTAL+1); VS_W = clog2(V_TOTAL+1).
REQ-007 SHALL have port clk_i, input, 1, the single system clock; all logic on its rising edge.
REQ-008 SHALL have port rst_i, input, 1, reset, synchronous and active-high.
REQ-009 SHALL have port hsync_o, output, 1, horizontal sync, active-low.
REQ-010 SHALL have port vsync_o, output, 1, vertical sync, active-low.
REQ-011 SHALL have port x_o, output, HS_W, current pixel column 0..H_TOTAL-1.
REQ-012 SHALL have port y_o, output, VS_W, current line 0..V_TOTAL-1.
REQ-013 SHALL have port visible_o, output, 1, high when (x_o,y_o) lies in the visible area.
REQ-014 SHALL have port px_tick_o, output, 1, one-clock strobe marking the cycle in which new outputs first become valid.
REQ-015 SHALL have port frame_start_o, output, 1, one-clock strobe when position (0,0) is presented.

Function
REQ-016 SHALL contain a pixel divider px_cnt counting 0..PX_DIV-1 and wrapping; the internal tick is true in each cycle where px_cnt == PX_DIV-1 (every cycle when PX_DIV=1).
REQ-017 SHALL contain h_cnt, which advances only on tick and wraps from H_TOTAL-1 to 0.
REQ-018 SHALL contain v_cnt, which advances only on a tick where h_cnt wraps, and itself wraps from V_TOTAL-1 to 0; the simultaneous h and v wrap at (H_TOTAL-1,V_TOTAL-1) yields (0,0).
REQ-019 SHALL, on each tick edge, register the outputs from the pre-advance counter values; outputs lag the counters by exactly one tick.
REQ-020 SHALL hold all outputs except the strobes constant between tick edges.
REQ-021 SHALL drive hsync_o low iff H_RES+H_FP <= x_o < H_RES+H_FP+H_SYNC (656..751).
REQ-022 SHALL drive vsync_o low iff V_RES+V_FP <= y_o < V_RES+V_FP+V_SYNC (490..491), spanning whole lines.
REQ-023 SHALL drive visible_o high iff x_o < H_RES and y_o < V_RES.
REQ-024 SHALL assert px_tick_o for exactly one clock following every tick edge.
REQ-025 SHALL assert frame_start_o for exactly that clock only when the newly loaded position is (0,0).
REQ-026 SHALL contain no combinational path from counters to output ports; all outputs are flops.

Reset
REQ-027 SHALL, while rst_i is high at a clock edge, load px_cnt=0, h_cnt=0, v_cnt=0, x_o=0, y_o=0, hsync_o=1, vsync_o=1, visible_o=0, px_tick_o=0, frame_start_o=0.
REQ-028 SHALL apply reset mid-frame or mid-divider identically, with no residual strobe; timing restarts from the first tick after release.
REQ-029 SHALL make the first tick edge after reset present (0,0) with visible_o=1 and frame_start_o=1.

Verification
REQ-030 SHALL cover reset release, PX_DIV=2 -> on the 2nd edge after release, x_o=0, y_o=0, visible_o=1, px_tick_o=1, frame_start_o=1; on the 3rd edge both strobes are 0.
REQ-031 SHALL cover a full line -> px_tick_o period of 2 clocks; x_o 0..799 then 0; hsync_o low for exactly 96 ticks starting at x_o=656; visible_o low from x_o=640.
REQ-032 SHALL cover a full frame -> frame_start_o every 420000 ticks (840000 clks); vsync_o low exactly for y_o 490..491 (1600 ticks); y_o wraps 524->0 together with x_o 799->0.
REQ-033 SHALL cover reset asserted at x_o=300, y_o=200 for 3 clks -> all outputs at reset values; first tick after release presents (0,0) with frame_start_o=1.
REQ-034 SHALL cover PX_DIV=1 -> px_tick_o constantly high after the first edge; x_o increments every clock; line period 800 clks.
REQ-035 SHALL cover throughout all scenarios -> assertions that hsync_o, vsync_o, x_o, y_o and visible_o change only on edges where px_tick_o becomes 1.

Source files
------------

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA sync/position generator with pixel-clock divider.
// Outputs are registered from the pre-advance counters on each pixel tick.
module vga_timing_gen #(
    parameter int H_RES  = 640,
    parameter int V_RES  = 480,
    parameter int H_FP   = 16,
    parameter int H_SYNC = 96,
    parameter int H_BP   = 48,
    parameter int V_FP   = 10,
    parameter int V_SYNC = 2,
    parameter int V_BP   = 33,
    parameter int PX_DIV = 2,
    localparam int H_TOTAL = H_RES + H_FP + H_SYNC + H_BP,
    localparam int V_TOTAL = V_RES + V_FP + V_SYNC + V_BP,
    localparam int HS_W    = $clog2(H_TOTAL + 1),
    localparam int VS_W    = $clog2(V_TOTAL + 1)
) (
    input  logic            clk_i,
    input  logic            rst_i,
    output logic            hsync_o,
    output logic            vsync_o,
    output logic [HS_W-1:0] x_o,
    output logic [VS_W-1:0] y_o,
    output logic            visible_o,
    output logic            px_tick_o,
    output logic            frame_start_o
);

    localparam int PX_W = (PX_DIV > 1) ? $clog2(PX_DIV) : 1;

    localparam logic [PX_W-1:0] PX_LAST  = PX_W'(PX_DIV - 1);
    localparam logic [HS_W-1:0] H_LAST   = HS_W'(H_TOTAL - 1);
    localparam logic [HS_W-1:0] H_VIS    = HS_W'(H_RES);
    localparam logic [HS_W-1:0] HS_START = HS_W'(H_RES + H_FP);
    localparam logic [HS_W-1:0] HS_END   = HS_W'(H_RES + H_FP + H_SYNC);
    localparam logic [VS_W-1:0] V_LAST   = VS_W'(V_TOTAL - 1);
    localparam logic [VS_W-1:0] V_VIS    = VS_W'(V_RES);
    localparam logic [VS_W-1:0] VS_START = VS_W'(V_RES + V_FP);
    localparam logic [VS_W-1:0] VS_END   = VS_W'(V_RES + V_FP + V_SYNC);

    logic [PX_W-1:0] r_px_cnt;
    logic [HS_W-1:0] r_h_cnt;
    logic [VS_W-1:0] r_v_cnt;

    logic w_tick;
    logic w_h_wrap;
    logic w_v_wrap;
    logic w_origin;

    assign w_tick   = (r_px_cnt == PX_LAST);
    assign w_h_wrap = (r_h_cnt == H_LAST);
    assign w_v_wrap = (r_v_cnt == V_LAST);
    assign w_origin = (r_h_cnt == '0) && (r_v_cnt == '0);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_px_cnt      <= '0;
            r_h_cnt       <= '0;
            r_v_cnt       <= '0;
            x_o           <= '0;
            y_o           <= '0;
            hsync_o       <= 1'b1;
            vsync_o       <= 1'b1;
            visible_o     <= 1'b0;
            px_tick_o     <= 1'b0;
            frame_start_o <= 1'b0;
        end else begin
            px_tick_o     <= w_tick;
            frame_start_o <= w_tick && w_origin;
            r_px_cnt      <= w_tick ? '0 : r_px_cnt + 1'b1;
            if (w_tick) begin
                // Position outputs trail the counters by one tick.
                x_o       <= r_h_cnt;
                y_o       <= r_v_cnt;
                hsync_o   <= !((r_h_cnt >= HS_START) && (r_h_cnt < HS_END));
                vsync_o   <= !((r_v_cnt >= VS_START) && (r_v_cnt < VS_END));
                visible_o <= (r_h_cnt < H_VIS) && (r_v_cnt < V_VIS);
                r_h_cnt   <= w_h_wrap ? '0 : r_h_cnt + 1'b1;
                if (w_h_wrap) begin
                    r_v_cnt <= w_v_wrap ? '0 : r_v_cnt + 1'b1;
                end
            end
        end
    end

endmodule
